// File: rtl/sync_d_upcounter.sv
// Synchronous modulo-MODULUS up counter: registered q/qbar, one-cycle wrap pulse,
// sticky ovf and combinational tc for cascading. Define D_UPCOUNTER_SAT_EN to saturate instead of wrapping.
module sync_d_upcounter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qbar_q, qbar_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;
  logic             at_max;
  logic             load_ok;

  assign at_max  = (q_q == MAX_VAL);
  assign load_ok = (32'(load_val) < MODULUS);

  // NOTE: every signal written here gets a default first, so no path through the
  // if/else chain can leave one unassigned and infer a latch.
  always_comb begin
    q_d     = q_q;
    wrap_d  = 1'b0;
    ovf_set = 1'b0;
    if (load) begin
      q_d = load_ok ? load_val : '0;
    end else if (en && at_max) begin
`ifdef D_UPCOUNTER_SAT_EN
      q_d     = q_q;
      ovf_set = 1'b1;
`else
      q_d     = '0;
      wrap_d  = 1'b1;
      ovf_set = 1'b1;
`endif
    end else if (en) begin
      q_d = q_q + WIDTH'(1);
    end
    qbar_d = ~q_d;
    ovf_d  = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their inputs before any of them updates on the shared edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= RST_VAL;
      qbar_q <= ~RST_VAL;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      qbar_q <= qbar_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  // tc stays combinational so the next cascaded stage advances on the same edge.
  assign tc   = at_max && en;
  assign q    = q_q;
  assign qbar = qbar_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_sync_d_upcounter.sv
// Scoreboard bench for sync_d_upcounter: a modulo-16 and a modulo-10 instance,
// directed stimulus pushes expected state, a monitor pops and compares.
module tb_sync_d_upcounter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en16, ld16, oc16, en10, ld10, oc10;
  logic [3:0] lv16, lv10;
  logic [3:0] q16, qb16, q10, qb10;
  logic       tc16, wr16, ov16, tc10, wr10, ov10;

  sync_d_upcounter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en16), .load(ld16), .load_val(lv16), .ovf_clr(oc16),
    .q(q16), .qbar(qb16), .tc(tc16), .wrap(wr16), .ovf(ov16)
  );

  sync_d_upcounter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut10 (
    .clk(clk), .rst_n(rst_n), .en(en10), .load(ld10), .load_val(lv10), .ovf_clr(oc10),
    .q(q10), .qbar(qb10), .tc(tc10), .wrap(wr10), .ovf(ov10)
  );

  typedef struct {
    int         dut;
    logic [3:0] q;
    logic       tc;
    logic       wrap;
    logic       ovf;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic compare(input exp_t e);
    if (e.dut == 0) begin
      check({e.name, ".q"},    q16,        e.q);
      check({e.name, ".qbar"}, qb16,       ~e.q);
      check({e.name, ".tc"},   4'(tc16),   4'(e.tc));
      check({e.name, ".wrap"}, 4'(wr16),   4'(e.wrap));
      check({e.name, ".ovf"},  4'(ov16),   4'(e.ovf));
    end else begin
      check({e.name, ".q"},    q10,        e.q);
      check({e.name, ".qbar"}, qb10,       ~e.q);
      check({e.name, ".tc"},   4'(tc10),   4'(e.tc));
      check({e.name, ".wrap"}, 4'(wr10),   4'(e.wrap));
      check({e.name, ".ovf"},  4'(ov10),   4'(e.ovf));
    end
  endtask

  // Monitor: outputs are presented after each edge (sampled mid-cycle) and
  // immediately after an asynchronous reset.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        compare(e);
      end
    end
  end

  // Drive inputs for the next edge and push the expected state now visible
  // (result of the previous edge); tc reflects the newly driven en.
  task automatic step(input int d, input bit e, input bit l, input logic [3:0] v, input bit c,
                      input logic [3:0] eq, input bit et, input bit ew, input bit eo,
                      input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    if (d == 0) begin
      en16 = e; ld16 = l; lv16 = v; oc16 = c;
    end else begin
      en10 = e; ld10 = l; lv10 = v; oc10 = c;
    end
    x.dut = d; x.q = eq; x.tc = et; x.wrap = ew; x.ovf = eo; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic push_exp(input int d, input logic [3:0] eq, input bit et, input bit ew,
                          input bit eo, input string nm);
    exp_t x;
    x.dut = d; x.q = eq; x.tc = et; x.wrap = ew; x.ovf = eo; x.name = nm;
    sb.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    logic [3:0] eq;
    rst_n = 1'b0;
    en16 = 0; ld16 = 0; lv16 = '0; oc16 = 0;
    en10 = 0; ld10 = 0; lv10 = '0; oc10 = 0;

    step(0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, "reset16");
    step(1, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, "reset10");
    @(negedge clk);
    #2 rst_n = 1'b1;

`ifdef D_UPCOUNTER_SAT_EN
    for (int k = 0; k <= 20; k++) begin
      eq = (k > 15) ? 4'd15 : 4'(k);
      step(0, 1, 0, 4'd0, 0, eq, eq == 4'd15, 0, k >= 16, $sformatf("sat16[%0d]", k));
    end
    step(0, 0, 0, 4'd0, 0, 4'd15, 0, 0, 1, "sat_hold");
    step(0, 0, 0, 4'd0, 0, 4'd15, 0, 0, 1, "sat_final");
`else
    // Free run, modulo 16: 0..15 then wrap once
    for (int k = 0; k <= 20; k++) begin
      eq = 4'(k % 16);
      step(0, 1, 0, 4'd0, 0, eq, eq == 4'd15, k == 16, k >= 16, $sformatf("run16[%0d]", k));
    end
    // Load priority over en, then a load issued while at the terminal count
    step(0, 1, 1, 4'd12, 0, 4'd5,  0, 0, 1, "load_at5");
    step(0, 1, 1, 4'd15, 0, 4'd12, 0, 0, 1, "load_12");
    step(0, 1, 1, 4'd3,  0, 4'd15, 1, 0, 1, "load_at_tc");
    step(0, 0, 0, 4'd0,  0, 4'd3,  0, 0, 1, "no_wrap_on_load");
    step(0, 0, 0, 4'd0,  0, 4'd3,  0, 0, 1, "hold16");

    // Modulo 10: 0..9, wrap every 10 cycles
    for (int k = 0; k <= 21; k++) begin
      eq = 4'(k % 10);
      step(1, 1, 0, 4'd0, 0, eq, eq == 4'd9, (k == 10) || (k == 20), k >= 10,
           $sformatf("run10[%0d]", k));
    end
    // Out-of-range load goes to 0; then sticky flag set-vs-clear
    step(1, 1, 1, 4'd14, 0, 4'd2, 0, 0, 1, "load_oob");
    step(1, 1, 1, 4'd9,  0, 4'd0, 0, 0, 1, "oob_to0");
    step(1, 1, 0, 4'd0,  1, 4'd9, 1, 0, 1, "tc9_with_clr");
    step(1, 0, 0, 4'd0,  1, 4'd0, 0, 1, 1, "set_wins");
    step(1, 1, 0, 4'd0,  0, 4'd0, 0, 0, 0, "clr_alone");
    for (int k = 1; k <= 7; k++) begin
      step(1, 1, 0, 4'd0, 0, 4'(k), 0, 0, 0, $sformatf("pre_rst[%0d]", k));
    end

    // Asynchronous reset between edges at q=7 (dut16 holds ovf=1 here)
    #6;
    push_exp(0, 4'd0, 0, 0, 0, "async_rst16");
    push_exp(1, 4'd0, 0, 0, 0, "async_rst10");
    rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1, 0, 0, 4'd0, 0, 4'd1, 0, 0, 0, "first_count_after_rst");
    step(1, 0, 0, 4'd0, 0, 4'd1, 0, 0, 0, "hold10");
`endif

    @(negedge clk);
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
